// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and sizing helper for the sequential ALU.
package alu_seq_pkg;

    localparam logic [4:0] ALU_ADD    = 5'h00;
    localparam logic [4:0] ALU_SLL    = 5'h01;
    localparam logic [4:0] ALU_XOR    = 5'h04;
    localparam logic [4:0] ALU_SRL    = 5'h05;
    localparam logic [4:0] ALU_OR     = 5'h06;
    localparam logic [4:0] ALU_AND    = 5'h07;
    localparam logic [4:0] ALU_SUB    = 5'h08;
    localparam logic [4:0] ALU_SRA    = 5'h0D;
    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_DIV    = 5'h14;
    localparam logic [4:0] ALU_DIVU   = 5'h15;
    localparam logic [4:0] ALU_REM    = 5'h16;
    localparam logic [4:0] ALU_REMU   = 5'h17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Select width that never collapses to zero bits for single-channel configurations.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage operand muxes, alu_seq and writeback.
interface alu_seq_if #(
    parameter int WIDTH  = 32,
    parameter int N_SRCA = 3,
    parameter int N_SRCB = 4
);
    localparam int SELA_W = alu_seq_pkg::sel_w(N_SRCA);
    localparam int SELB_W = alu_seq_pkg::sel_w(N_SRCB);

    logic                      i_InValid;
    logic                      o_InReady;
    logic [4:0]                i_OpCode;
    logic [SELA_W-1:0]         i_SrcASel;
    logic [N_SRCA*WIDTH-1:0]   i_SrcA;
    logic [SELB_W-1:0]         i_SrcBSel;
    logic [N_SRCB*WIDTH-1:0]   i_SrcB;
    logic                      o_OutValid;
    logic                      i_OutReady;
    logic [WIDTH-1:0]          o_Result;
    logic                      o_Zero;
    logic                      o_Illegal;

    modport master (
        output i_InValid, i_OpCode, i_SrcASel, i_SrcA, i_SrcBSel, i_SrcB, i_OutReady,
        input  o_InReady, o_OutValid, o_Result, o_Zero, o_Illegal
    );

    modport slave (
        input  i_InValid, i_OpCode, i_SrcASel, i_SrcA, i_SrcBSel, i_SrcB, i_OutReady,
        output o_InReady, o_OutValid, o_Result, o_Zero, o_Illegal
    );

endinterface

// File: rtl/alu_seq_mdu.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) engine for RV32M ops.
// Only present when ALU_SEQ_MDU_EN is defined.
`ifdef ALU_SEQ_MDU_EN
module alu_seq_mdu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int              CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2:0] OP_MUL    = ALU_MUL[2:0];
    localparam logic [2:0] OP_MULHSU = ALU_MULHSU[2:0];
    localparam logic [2:0] OP_MULHU  = ALU_MULHU[2:0];
    localparam logic [2:0] OP_DIV    = ALU_DIV[2:0];
    localparam logic [2:0] OP_DIVU   = ALU_DIVU[2:0];
    localparam logic [2:0] OP_REM    = ALU_REM[2:0];
    localparam logic [2:0] OP_REMU   = ALU_REMU[2:0];

    function automatic logic [WIDTH-1:0] fix_sign(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_sgn = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
        b_sgn = a_sgn && (op != OP_MULHSU);
        a_neg = a_sgn & a[WIDTH-1];
        b_neg = b_sgn & b[WIDTH-1];
        a_mag = fix_sign(a_neg, a);
        b_mag = fix_sign(b_neg, b);
    end

    logic [2:0]       op_p0;
    logic             neg_p0, div0_p0, ovf_p0;
    logic [WIDTH-1:0] dvd_p0, mcand_p0;
    logic [WIDTH-1:0] hi_p1, lo_p1;
    logic [CW-1:0]    cnt_p1;

    always_ff @(posedge clk) begin
        if (rst)        cnt_p1 <= '0;
        else if (start) cnt_p1 <= '0;
        else if (run)   cnt_p1 <= cnt_p1 + 1'b1;
    end

    // Accept: magnitudes and sign/special-case flags captured once; hi/lo iterate in place.
    logic [WIDTH-1:0] hi_n, lo_n;

    always_ff @(posedge clk) begin
        if (start) begin
            op_p0    <= op;
            neg_p0   <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            div0_p0  <= (b == '0);
            ovf_p0   <= ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
            dvd_p0   <= a;
            hi_p1    <= '0;
            lo_p1    <= op[2] ? a_mag : b_mag;
            mcand_p0 <= op[2] ? b_mag : a_mag;
        end else if (run) begin
            hi_p1 <= hi_n;
            lo_p1 <= lo_n;
        end
    end

    logic [WIDTH:0] sum, shifted, diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_n    = hi_p1;
        lo_n    = lo_p1;
        if (op_p0[2]) begin
            shifted = {hi_p1, lo_p1[WIDTH-1]};
            diff    = shifted - {1'b0, mcand_p0};
            if (!diff[WIDTH]) begin
                hi_n = diff[WIDTH-1:0];
                lo_n = {lo_p1[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo_p1[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum          = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, mcand_p0} : '0);
            {hi_n, lo_n} = {sum, lo_p1[WIDTH-1:1]};
        end
    end

    // Sign fix-up is applied to the final iteration's values so the result lands with done.
    logic [2*WIDTH-1:0] prod, prod_f;

    always_comb begin
        prod   = {hi_n, lo_n};
        prod_f = neg_p0 ? -prod : prod;
        case (op_p0)
            OP_MUL:           result = prod_f[WIDTH-1:0];
            OP_DIV, OP_DIVU:  result = div0_p0 ? '1 : (ovf_p0 ? MIN_VAL : fix_sign(neg_p0, lo_n));
            OP_REM, OP_REMU:  result = div0_p0 ? dvd_p0 : (ovf_p0 ? '0 : fix_sign(neg_p0, hi_n));
            default:          result = prod_f[2*WIDTH-1:WIDTH];
        endcase
    end

    assign done = run && (cnt_p1 == LAST);

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: source muxing, single-cycle base ops, registered handshake output.
// Define ALU_SEQ_MDU_EN to add the iterative RV32M multiply/divide path (alu_seq_mdu).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_SRCA = 3,
    parameter int N_SRCB = 4
) (
    input  logic     i_Clk,
    input  logic     i_Reset,
    alu_seq_if.slave bus
);
    localparam int SHW    = $clog2(WIDTH);
    localparam int SELA_W = sel_w(N_SRCA);
    localparam int SELB_W = sel_w(N_SRCB);

    logic signed [WIDTH-1:0] src_a, src_b;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        src_a = bus.i_SrcA[WIDTH-1:0];
        for (int k = 1; k < N_SRCA; k++)
            if (bus.i_SrcASel == k[SELA_W-1:0]) src_a = bus.i_SrcA[k*WIDTH +: WIDTH];
        src_b = bus.i_SrcB[WIDTH-1:0];
        for (int k = 1; k < N_SRCB; k++)
            if (bus.i_SrcBSel == k[SELB_W-1:0]) src_b = bus.i_SrcB[k*WIDTH +: WIDTH];
    end

    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] base_res;
    logic                    base_ill;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (bus.i_OpCode)
            ALU_ADD: base_res = src_a + src_b;
            ALU_SUB: base_res = src_a - src_b;
            ALU_AND: base_res = src_a & src_b;
            ALU_OR:  base_res = src_a | src_b;
            ALU_XOR: base_res = src_a ^ src_b;
            ALU_SLL: base_res = src_a << shamt;
            ALU_SRL: base_res = src_a >> shamt;
            ALU_SRA: base_res = src_a >>> shamt;
            default: base_ill = 1'b1;
        endcase
    end

    state_t           state;
    logic             in_ready_p1, vld_p1, zero_p1, illegal_p1;
    logic [WIDTH-1:0] result_p1;

`ifdef ALU_SEQ_MDU_EN
    logic             is_m, mdu_start, mdu_run, mdu_done;
    logic [WIDTH-1:0] mdu_res;

    assign is_m      = (bus.i_OpCode[4:3] == 2'b10);
    assign mdu_start = (state == S_IDLE) && bus.i_InValid && is_m;
    assign mdu_run   = (state == S_BUSY);

    alu_seq_mdu #(.WIDTH(WIDTH)) u_mdu (
        .clk    (i_Clk),
        .rst    (i_Reset),
        .start  (mdu_start),
        .run    (mdu_run),
        .op     (bus.i_OpCode[2:0]),
        .a      (src_a),
        .b      (src_b),
        .done   (mdu_done),
        .result (mdu_res)
    );
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            in_ready_p1 <= 1'b1;
            vld_p1      <= 1'b0;
            result_p1   <= '0;
            zero_p1     <= 1'b1;
            illegal_p1  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.i_InValid) begin
                    in_ready_p1 <= 1'b0;
`ifdef ALU_SEQ_MDU_EN
                    if (is_m) state <= S_BUSY;
                    else
`endif
                    begin
                        state      <= S_DONE;
                        vld_p1     <= 1'b1;
                        result_p1  <= base_res;
                        zero_p1    <= (base_res == '0);
                        illegal_p1 <= base_ill;
                    end
                end
`ifdef ALU_SEQ_MDU_EN
                S_BUSY: if (mdu_done) begin
                    state      <= S_DONE;
                    vld_p1     <= 1'b1;
                    result_p1  <= mdu_res;
                    zero_p1    <= (mdu_res == '0);
                    illegal_p1 <= 1'b0;
                end
`endif
                S_DONE: if (bus.i_OutReady) begin
                    state       <= S_IDLE;
                    vld_p1      <= 1'b0;
                    in_ready_p1 <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    vld_p1      <= 1'b0;
                    in_ready_p1 <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_InReady  = in_ready_p1;
    assign bus.o_OutValid = vld_p1;
    assign bus.o_Result   = result_p1;
    assign bus.o_Zero     = zero_p1;
    assign bus.o_Illegal  = illegal_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver queues expected responses, a forked monitor checks each output.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W  = 32;
    localparam int NA = 3;
    localparam int NB = 4;
`ifdef ALU_SEQ_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .N_SRCA(NA), .N_SRCB(NB)) bus ();

    alu_seq #(.WIDTH(W), .N_SRCA(NA), .N_SRCB(NB)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", nm, ncyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_srcs(input int asel, input int bsel, input logic [31:0] a, input logic [31:0] b);
        logic [NA*W-1:0] sa;
        logic [NB*W-1:0] sb;
        int ia, ib;
        for (int k = 0; k < NA; k++) sa[k*W +: W] = 32'h5A5A_0100 + 32'(k);
        for (int k = 0; k < NB; k++) sb[k*W +: W] = 32'h3C3C_0200 + 32'(k);
        ia = (asel < NA) ? asel : 0;
        ib = (bsel < NB) ? bsel : 0;
        sa[ia*W +: W] = a;
        sb[ib*W +: W] = b;
        bus.i_SrcA    = sa;
        bus.i_SrcB    = sb;
        bus.i_SrcASel = asel[1:0];
        bus.i_SrcBSel = bsel[1:0];
    endtask

    task automatic issue(input string nm, input logic [4:0] op, input int asel, input int bsel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic ill, input int lat, input int stall);
        bit ok;
        set_srcs(asel, bsel, a, b);
        bus.i_OpCode   = op;
        bus.i_InValid  = 1'b1;
        bus.i_OutReady = (stall == 0);
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bus.o_InReady) begin
                q.push_back('{nm, res, (res == 32'h0), ill, lat, ncyc});
                ok = 1;
            end
            step();
        end
        if (!ok) fail_now({nm, " accept"});
        bus.i_InValid = 1'b0;
        bus.i_OpCode  = ALU_SUB;
        set_srcs(1, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (bus.o_OutValid) ok = 1;
            else step();
        end
        if (!ok) fail_now({nm, " valid"});
        repeat (stall) step();
        bus.i_OutReady = 1'b1;
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
            if (!bus.o_OutValid) ok = 1;
            else step();
        end
        if (!ok) fail_now({nm, " release"});
    endtask

    task automatic issue_m(input string nm, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res);
        issue(nm, op, 0, 1, a, b, MDU ? res : 32'h0, !MDU, MDU ? 33 : 1, 0);
    endtask

    task automatic monitor();
        bit          seen;
        logic [31:0] hr;
        logic        hz, hil;
        int          first;
        exp_t        e;
        seen = 0; hr = '0; hz = 1'b0; hil = 1'b0; first = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else if (bus.o_OutValid) begin
                check("in_ready_while_valid", {31'b0, bus.o_InReady}, 32'h0);
                if (!seen) begin
                    seen = 1; first = ncyc;
                    hr = bus.o_Result; hz = bus.o_Zero; hil = bus.o_Illegal;
                end else begin
                    check("hold_result", bus.o_Result, hr);
                    check("hold_zero_illegal", {30'b0, bus.o_Zero, bus.o_Illegal}, {30'b0, hz, hil});
                end
                if (bus.i_OutReady) begin
                    seen = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%08h with nothing outstanding", bus.o_Result);
                    end else begin
                        e = q.pop_front();
                        check({e.name, " result"},  bus.o_Result, e.res);
                        check({e.name, " zero"},    {31'b0, bus.o_Zero},    {31'b0, e.zero});
                        check({e.name, " illegal"}, {31'b0, bus.o_Illegal}, {31'b0, e.ill});
                        check({e.name, " latency"}, 32'(first - e.acc), 32'(e.lat));
                    end
                end
            end
        end
    endtask

    initial begin
        bit ok;
        int nvalid;
        rst            = 1'b1;
        bus.i_InValid  = 1'b0;
        bus.i_OpCode   = ALU_ADD;
        bus.i_OutReady = 1'b1;
        set_srcs(0, 0, 32'h0, 32'h0);
        fork
            monitor();
        join_none
        repeat (3) step();

        check("reset in_ready",  {31'b0, bus.o_InReady},  32'h1);
        check("reset out_valid", {31'b0, bus.o_OutValid}, 32'h0);
        check("reset result",    bus.o_Result,            32'h0);
        check("reset zero",      {31'b0, bus.o_Zero},     32'h1);
        check("reset illegal",   {31'b0, bus.o_Illegal},  32'h0);
        rst = 1'b0;
        step();
        check("post_reset in_ready", {31'b0, bus.o_InReady}, 32'h1);

        issue("add_5_m7",     ALU_ADD, 2, 3, 32'd5,         32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1, 0);
        issue("sub_stall",    ALU_SUB, 1, 2, 32'd9,         32'd9,         32'h0000_0000, 1'b0, 1, 5);
        issue("sra_0x24",     ALU_SRA, 0, 1, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1, 0);
        issue("srl_4",        ALU_SRL, 1, 0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1, 0);
        issue("sll_31",       ALU_SLL, 2, 2, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1, 0);
        issue("and",          ALU_AND, 1, 3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1, 0);
        issue("or",           ALU_OR,  0, 2, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1, 0);
        issue("xor",          ALU_XOR, 2, 1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1, 0);
        issue("add_sel_oor",  ALU_ADD, 3, 1, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 1'b0, 1, 0);
        issue("illegal_1f",   5'h1F,   0, 0, 32'h1234_5678, 32'h1,         32'h0000_0000, 1'b1, 1, 0);
        issue("illegal_02",   5'h02,   1, 1, 32'h1,         32'h1,         32'h0000_0000, 1'b1, 1, 0);

        issue_m("mulh_min_min", ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue_m("mul_m3_7",     ALU_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB);
        issue_m("mulhu_max",    ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue_m("mulhsu_m1",    ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_m("div_7_0",      ALU_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF);
        issue_m("remu_7_0",     ALU_REMU,   32'd7,         32'd0,         32'd7);
        issue_m("rem_min_m1",   ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        issue_m("div_min_m1",   ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue_m("divu_100_7",   ALU_DIVU,   32'd100,       32'd7,         32'd14);
        issue_m("div_m7_2",     ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        issue_m("rem_m7_2",     ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);

        // Reset while an operation is outstanding: nothing may be delivered afterwards.
        bus.i_OutReady = 1'b0;
        set_srcs(0, 1, 32'd7, 32'd3);
        bus.i_OpCode  = ALU_DIV;
        bus.i_InValid = 1'b1;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bus.o_InReady) ok = 1;
            step();
        end
        if (!ok) fail_now("reset_mid accept");
        bus.i_InValid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        check("reset_mid out_valid", {31'b0, bus.o_OutValid}, 32'h0);
        check("reset_mid result",    bus.o_Result,            32'h0);
        check("reset_mid zero",      {31'b0, bus.o_Zero},     32'h1);
        check("reset_mid illegal",   {31'b0, bus.o_Illegal},  32'h0);
        rst = 1'b0;
        bus.i_OutReady = 1'b1;
        step();
        check("reset_mid in_ready", {31'b0, bus.o_InReady}, 32'h1);
        nvalid = 0;
        repeat (40) begin
            if (bus.o_OutValid) nvalid++;
            step();
        end
        check("reset_mid no_output", 32'(nvalid), 32'h0);

        issue("add_after_reset", ALU_ADD, 0, 0, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0);

        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (q.size() == 0) ok = 1;
            else step();
        end
        check("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
